// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the pipelined priority encoder.
// Imported by the design and the bench.
package prio_enc_pkg;

  localparam int unsigned NMin = 2;
  localparam int unsigned NMax = 64;

  // A vector has two or more set bits exactly when clearing its lowest set bit leaves a nonzero value.
  function automatic logic popcnt_ge2(input logic [NMax-1:0] v);
    return |(v & (v - NMax'(1)));
  endfunction

endpackage

// File: rtl/prio_enc_pipe_if.sv
// Request/result bundle for prio_enc_pipe.
// The master side drives requests and consumes results; the slave side is the encoder.
interface prio_enc_pipe_if #(
  parameter int unsigned N = 4
);

  localparam int unsigned W = $clog2(N);

  logic [N-1:0] req;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] idx;
  logic         any;
  logic         multi;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output req, in_valid, out_ready,
    input  in_ready, idx, any, multi, out_valid
  );

  modport slave (
    input  req, in_valid, out_ready,
    output in_ready, idx, any, multi, out_valid
  );

endinterface

// File: rtl/prio_enc_core.sv
// Combinational rotating priority search: scans downward from (start_i-1) mod N, wrapping.
// With start_i == 0 this reduces to "highest set bit wins".
module prio_enc_core #(
  parameter int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  int unsigned pos;

  // Visit candidates from lowest to highest priority so the last hit is the winner.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      pos = (32'(start_i) + N - 1 - 32'(j)) % N;
      if (req_i[pos]) begin
        idx_o = W'(pos);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_enc_pipe.sv
// One-stage registered priority encoder with valid/ready flow control.
// Define PRIO_ENC_PIPE_RR_EN for round-robin arbitration; otherwise fixed priority.
module prio_enc_pipe
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  prio_enc_pipe_if.slave bus
);

  localparam int unsigned W = $clog2(N);

  if (N < NMin || N > NMax) begin : g_n_check
    $error("prio_enc_pipe: N outside supported range");
  end

  logic [W-1:0] idx_q, idx_d;
  logic         any_q, any_d;
  logic         multi_q, multi_d;
  logic         valid_q, valid_d;

  logic         accept;
  logic [W-1:0] start;
  logic [W-1:0] core_idx;
  logic         core_any;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef PRIO_ENC_PIPE_RR_EN
  logic [W-1:0] ptr_q, ptr_d;

  assign start = ptr_q;

  // An empty vector grants nothing, so the rotation point stays put.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && core_any) begin
      ptr_d = core_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign start = '0;
`endif

  prio_enc_core #(
    .N(N)
  ) u_core (
    .req_i  (bus.req),
    .start_i(start),
    .idx_o  (core_idx),
    .any_o  (core_any)
  );

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    any_d   = any_q;
    multi_d = multi_q;
    if (accept) begin
      valid_d = 1'b1;
      idx_d   = core_idx;
      any_d   = core_any;
      multi_d = popcnt_ge2(NMax'(bus.req));
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      any_q   <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      any_q   <= any_d;
      multi_q <= multi_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.idx       = idx_q;
  assign bus.any       = any_q;
  assign bus.multi     = multi_q;

endmodule

// File: doc/prio_enc_pipe.md
PRIO_ENC_PIPE -- requirements
Module: prio_enc_pipe

Interface
REQ-001 Parameter N, default 4: number of request inputs; the legal range SHALL be 2..64.
REQ-002 Derived localparam W = $clog2(N): width of the index output.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  N  request vector; bit i is request i.
REQ-006 in_valid  input  1  req is valid this cycle.
REQ-007 in_ready  output  1  block can accept req this cycle.
REQ-008 idx  output  W  encoded index of the winning request.
REQ-009 any  output  1  at least one req bit was set in the accepted vector.
REQ-010 multi  output  1  two or more req bits were set in the accepted vector.
REQ-011 out_valid  output  1  idx/any/multi hold a result.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-013 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-014 Accept occurs when in_valid && in_ready; on accept the block SHALL register idx/any/multi from req and set out_valid=1 on the next edge, with exactly 1 cycle of latency.
REQ-015 When out_valid && out_ready and there is no accept, out_valid SHALL clear on the next edge.
REQ-016 When out_valid && !out_ready, idx/any/multi/out_valid SHALL hold unchanged, and in_ready=0 (back-pressure).
REQ-017 Simultaneous out_ready and accept SHALL replace the result with no bubble cycle, giving full throughput.
REQ-018 Fixed-priority mode: idx SHALL be the highest-numbered set bit of req.
REQ-019 req == 0: the block SHALL produce idx=0, any=0, multi=0, and out_valid is still asserted; an all-zero vector is a legal transaction.
REQ-020 multi SHALL be 1 iff popcount(req) >= 2, independent of priority mode.
REQ-021 Inputs req/in_valid sampled while in_ready=0 SHALL be ignored.

Reset
REQ-022 While rst_n=0, the block SHALL force out_valid=0, idx=0, any=0, multi=0, and round-robin pointer=0, asynchronously.
REQ-023 A result pending when reset asserts mid-operation SHALL be discarded.
REQ-024 On the first edge after rst_n rises, the block SHALL behave as idle: in_ready=1.

Configuration
REQ-025 Macro PRIO_ENC_PIPE_RR_EN: when defined, the block SHALL operate in round-robin mode; when undefined, it SHALL use fixed priority (REQ-018) and SHALL contain no pointer register.
REQ-026 Round-robin mode: the search order SHALL be descending, starting at (ptr-1) mod N and wrapping from 0 to N-1; the first set bit found is the winner.
REQ-027 Round-robin mode: on an accept with any=1, ptr SHALL load the winning idx; on accept with req==0, ptr SHALL be unchanged.
REQ-028 With ptr=0 after reset, the first round-robin decision SHALL equal the fixed-priority decision.

Structure
REQ-029 Package prio_enc_pkg SHALL hold the N range limits and a popcount-ge-2 function shared by design and bench.
REQ-030 Sub-module prio_enc_core SHALL be purely combinational (vector plus start offset -> idx, any); the top holds the registers, handshake and ptr.

Verification (N=4)
REQ-031 Reset, then apply req=4'b0001, in_valid=1, out_ready=1 -> the next cycle gives out_valid=1, idx=0, any=1, multi=0.
REQ-032 Apply in sequence 0001, 0010, 0100, 1000 on consecutive cycles with out_ready=1 -> results idx=0,1,2,3 on consecutive cycles with no bubble.
REQ-033 req=4'b1010 in fixed mode -> idx=3, multi=1; req=0000 -> idx=0, any=0, out_valid=1.
REQ-034 Hold out_ready=0 for 3 cycles after a result, while presenting new req -> idx holds, in_ready=0, and the new req is not captured until out_ready=1.
REQ-035 RR_EN defined, req=4'b1111 accepted 5 times -> idx=3,2,1,0,3.
REQ-036 Assert rst_n=0 mid-stall with out_valid=1 -> all outputs go to 0 immediately, and the next RR grant for 1111 is idx=3.
